// File: rtl/line_fill_sched_pkg.sv
// line_fill_sched_pkg: fill FSM states and one-hot line buffer selects
package line_fill_sched_pkg;
  typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DRAIN, FILL_DONE} fill_state_t;
  localparam logic [1:0] BUFF_A = 2'b01;
  localparam logic [1:0] BUFF_B = 2'b10;
endpackage

// File: rtl/line_fill_sched.sv
// line_fill_sched: fills line buffers A/B from frame memory and slots host writes into idle cycles
module line_fill_sched
  import line_fill_sched_pkg::*;
#(
  parameter int TILE_PER_LINE = 160,
  parameter int TILE_LINES    = 120,
  parameter int DATA_WIDTH    = 12,
  parameter int ADDR_WIDTH    = $clog2(TILE_PER_LINE*TILE_LINES),
  parameter int LBUF_AW       = $clog2(TILE_PER_LINE)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  frame_start_i,
  input  logic [1:0]            buff_fill_req_i,
  output logic [1:0]            buff_fill_done_o,
  input  logic                  host_req_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  output logic                  host_gnt_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]            lbuf_we_o,
  output logic [LBUF_AW-1:0]    lbuf_addr_o,
  output logic [DATA_WIDTH-1:0] lbuf_wdata_o
);
  localparam int ROW_W = $clog2(TILE_LINES);
  fill_state_t state_q, state_d;
  logic [1:0] sel_q, sel_d, pend_q, pend_d, lbuf_we_q, lbuf_we_d, req_all;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, rd_addr_q, rd_addr_d;
  logic [LBUF_AW-1:0] k_q, k_d, lbuf_addr_q, lbuf_addr_d;
  logic rewind_q, rewind_d, host_wr, wrap;
  assign req_all = pend_q | buff_fill_req_i;
  assign wrap = rewind_q | frame_start_i | (row_q == ROW_W'(TILE_LINES-1));
  assign host_gnt_o = rstn_i & host_req_i & (state_q == FILL_IDLE) & ~|req_all;
  assign host_wr = host_gnt_o & (32'(host_addr_i) < TILE_PER_LINE*TILE_LINES);
  assign mem_en_o = (state_q == FILL_RUN) | host_wr;
  assign mem_we_o = host_wr;
  assign mem_addr_o = (state_q == FILL_RUN) ? rd_addr_q : host_wr ? host_addr_i : '0;
  assign mem_wdata_o = host_wr ? host_data_i : '0;
  assign lbuf_we_o = lbuf_we_q;
  assign lbuf_addr_o = lbuf_addr_q;
  assign lbuf_wdata_o = |lbuf_we_q ? mem_rdata_i : '0;
  assign buff_fill_done_o = (state_q == FILL_DONE) ? sel_q : 2'b00;
  // next-state: pick a pending buffer, stream its row, then advance or rewind the row pointer
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    pend_d = req_all;
    row_d = row_q;
    base_d = base_q;
    rd_addr_d = rd_addr_q;
    k_d = k_q;
    rewind_d = rewind_q | frame_start_i;
    lbuf_we_d = (state_q == FILL_RUN) ? sel_q : 2'b00;
    lbuf_addr_d = (state_q == FILL_RUN) ? k_q : '0;
    case (state_q)
      FILL_IDLE: begin
        if (rewind_d) begin
          row_d = '0;
          base_d = '0;
          rewind_d = 1'b0;
        end
        if (|req_all) begin
          state_d = FILL_RUN;
          sel_d = req_all[0] ? BUFF_A : BUFF_B;
          pend_d = req_all & ~sel_d;
          rd_addr_d = base_d;
          k_d = '0;
        end
      end
      FILL_RUN: begin
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        k_d = k_q + LBUF_AW'(1);
        state_d = (k_q == LBUF_AW'(TILE_PER_LINE-1)) ? FILL_DRAIN : FILL_RUN;
      end
      FILL_DRAIN: state_d = FILL_DONE;
      default: begin
        state_d = FILL_IDLE;
        row_d = wrap ? '0 : row_q + ROW_W'(1);
        base_d = wrap ? '0 : base_q + ADDR_WIDTH'(TILE_PER_LINE);
        rewind_d = 1'b0;
      end
    endcase
  end
  // state registers; reset aborts any fill without a done pulse
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FILL_IDLE;
      sel_q <= '0;
      pend_q <= '0;
      row_q <= '0;
      base_q <= '0;
      rd_addr_q <= '0;
      k_q <= '0;
      rewind_q <= 1'b0;
      lbuf_we_q <= '0;
      lbuf_addr_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      row_q <= row_d;
      base_q <= base_d;
      rd_addr_q <= rd_addr_d;
      k_q <= k_d;
      rewind_q <= rewind_d;
      lbuf_we_q <= lbuf_we_d;
      lbuf_addr_q <= lbuf_addr_d;
    end
  end
endmodule

// File: tb/tb_line_fill_sched.sv
// tb_line_fill_sched: scoreboard bench with a row-level reference model and a 1-cycle RAM
module tb_line_fill_sched;
  localparam int N = 160, L = 120, AW = 15, DW = 12, LAW = 8, MEMSZ = N*L;
  logic clk = 0, rstn_i = 0, frame_start_i = 0, host_req_i = 0;
  logic [1:0] buff_fill_req_i = '0, buff_fill_done_o, lbuf_we_o;
  logic [AW-1:0] host_addr_i = '0, mem_addr_o;
  logic [DW-1:0] host_data_i = '0, mem_wdata_o, mem_rdata_i = '0, lbuf_wdata_o;
  logic host_gnt_o, mem_en_o, mem_we_o;
  logic [LAW-1:0] lbuf_addr_o;
  logic [DW-1:0] ram [MEMSZ];
  logic [DW-1:0] ref_mem [MEMSZ];
  typedef struct { logic [1:0] we; logic [LAW-1:0] addr; logic [DW-1:0] data; } lb_t;
  lb_t lb_q[$];
  logic [AW-1:0] rd_q[$];
  logic [1:0] done_q[$];
  logic [AW+DW-1:0] wr_q[$];
  int checks = 0, errors = 0, row = 0, dones = 0, cyc = 0, done_cyc = 0, c0 = 0;
  logic last_wr = 0;

  line_fill_sched dut (
    .clk_i(clk), .rstn_i(rstn_i), .frame_start_i(frame_start_i),
    .buff_fill_req_i(buff_fill_req_i), .buff_fill_done_o(buff_fill_done_o),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
    .host_gnt_o(host_gnt_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .lbuf_we_o(lbuf_we_o), .lbuf_addr_o(lbuf_addr_o), .lbuf_wdata_o(lbuf_wdata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame RAM: registered read data, writes land at the clock edge
  always @(posedge clk) begin
    if (mem_en_o && !mem_we_o) mem_rdata_i <= (mem_addr_o < MEMSZ) ? ram[mem_addr_o] : '0;
    if (mem_en_o && mem_we_o && mem_addr_o < MEMSZ) ram[mem_addr_o] <= mem_wdata_o;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // reference model: one row per fill, rows advance by one and wrap after L
  task automatic push_fill(input logic [1:0] b);
    for (int k = 0; k < N; k++) begin
      rd_q.push_back(AW'(row*N + k));
      lb_q.push_back('{b, LAW'(k), ref_mem[row*N + k]});
    end
    done_q.push_back(b);
    row = (row + 1) % L;
  endtask

  task automatic req(input logic [1:0] b, input bit push);
    @(posedge clk); #1;
    if (push && b[0]) push_fill(2'b01);
    if (push && b[1]) push_fill(2'b10);
    buff_fill_req_i = b;
    c0 = cyc + 1;
    @(posedge clk); #1;
    buff_fill_req_i = '0;
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    frame_start_i = 1;
    row = 0;
    @(posedge clk); #1;
    frame_start_i = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((rd_q.size() != 0 || lb_q.size() != 0 || done_q.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("idle_timeout", t < 2000, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    if (a < MEMSZ) begin
      wr_q.push_back({a, d});
      ref_mem[a] = d;
    end
    @(posedge clk); #1;
    host_req_i = 1;
    host_addr_i = a;
    host_data_i = d;
    do begin @(negedge clk); t++; end while (!host_gnt_o && t < 2000);
    chk("host_gnt_seen", host_gnt_o, 1);
    if (a >= MEMSZ) chk("oor_mem_en", mem_en_o, 0);
    @(posedge clk); #1;
    host_req_i = 0;
  endtask

  // monitor: pops expectations whenever the DUT presents a memory access, line write or done
  initial forever begin
    @(negedge clk);
    if (!rstn_i) last_wr = 0;
    else begin
      if (host_gnt_o) chk("gnt_while_fill", done_q.size(), 0);
      if (!mem_we_o) chk("wdata_zero", mem_wdata_o, 0);
      if (mem_en_o && !mem_we_o) begin
        if (rd_q.size() == 0) chk("rd_unexpected", mem_addr_o, 'hx);
        else chk("rd_addr", mem_addr_o, rd_q.pop_front());
      end
      if (mem_en_o && mem_we_o) begin
        if (wr_q.size() == 0) chk("wr_unexpected", mem_addr_o, 'hx);
        else chk("host_wr", {mem_addr_o, mem_wdata_o}, wr_q.pop_front());
      end
      if (lbuf_we_o != 0) begin
        if (lb_q.size() == 0) chk("lb_unexpected", lbuf_we_o, 0);
        else begin
          lb_t e;
          e = lb_q.pop_front();
          chk("lb_we", lbuf_we_o, e.we);
          chk("lb_addr", lbuf_addr_o, e.addr);
          chk("lb_data", lbuf_wdata_o, e.data);
        end
      end
      if (buff_fill_done_o != 0 || last_wr) begin
        chk("done_timing", buff_fill_done_o != 0, last_wr);
        if (buff_fill_done_o != 0) begin
          dones++;
          done_cyc = cyc;
          if (done_q.size() == 0) chk("done_unexpected", buff_fill_done_o, 0);
          else chk("done_sel", buff_fill_done_o, done_q.pop_front());
        end
      end
      last_wr = (lbuf_we_o != 0) && (lbuf_addr_o == LAW'(N-1));
    end
  end

  initial begin
    int d0, t, tgt;
    logic [1:0] p, q;
    for (int a = 0; a < MEMSZ; a++) begin
      ram[a] = DW'(a);
      ref_mem[a] = DW'(a);
    end
    host_req_i = 1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {buff_fill_done_o, host_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
                       lbuf_we_o, lbuf_addr_o, lbuf_wdata_o}, 0);
    host_req_i = 0;
    @(posedge clk); #1;
    rstn_i = 1;
    repeat (2) @(posedge clk);
    req(2'b01, 1);
    wait_idle();
    chk("done_latency", done_cyc - c0, N + 1);
    req(2'b11, 1);
    wait_idle();
    req(2'b01, 1);
    d0 = dones;
    host_write(AW'(100), DW'('hABC));
    chk("gnt_after_done", dones, d0 + 1);
    wait_idle();
    chk("ram100", ram[100], 'hABC);
    host_write(AW'(MEMSZ), DW'('h555));
    req(2'b10, 1);
    wait_idle();
    req(2'b01, 1);
    repeat (30) @(posedge clk);
    frame_start();
    wait_idle();
    req(2'b10, 1);
    wait_idle();
    frame_start();
    for (int i = 0; i < L; i++) begin
      req(i[0] ? 2'b10 : 2'b01, 1);
      wait_idle();
    end
    req(2'b01, 1);
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_en_o && t < 100);
    chk("wrap_first_addr", mem_addr_o, 0);
    wait_idle();
    for (int r = 0; r < 15; r++) begin
      p = 2'($urandom_range(1, 3));
      req(p, 1);
      if (p != 2'b11 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 60)) @(posedge clk);
        q = 2'($urandom_range(1, 2));
        req(q, 1);
        if ($urandom_range(0, 1) == 1) req(q, 0);
      end
      wait_idle();
      if ($urandom_range(0, 2) == 0) host_write(AW'($urandom_range(0, MEMSZ + 50)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) frame_start();
    end
    tgt = row*N + 50;
    req(2'b01, 1);
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(mem_en_o && !mem_we_o && mem_addr_o == AW'(tgt)) && t < 500);
    chk("rd50_seen", t < 500, 1);
    @(posedge clk); #1;
    rstn_i = 0;
    rd_q.delete();
    lb_q.delete();
    done_q.delete();
    row = 0;
    d0 = dones;
    @(negedge clk);
    chk("abort_outs", {buff_fill_done_o, host_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
                       lbuf_we_o, lbuf_addr_o, lbuf_wdata_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn_i = 1;
    repeat (200) @(posedge clk);
    chk("no_done_after_abort", dones, d0);
    req(2'b01, 1);
    wait_idle();
    chk("queues_empty", rd_q.size() + lb_q.size() + done_q.size() + wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
